// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

    // Memory-access handshake states.
    typedef enum logic {
        StIdle,
        StMemWait
    } state_e;

    // ALU operand forward selects.
    localparam logic [1:0] FWD_RF = 2'b00;  // register file
    localparam logic [1:0] FWD_W  = 2'b01;  // Writeback result
    localparam logic [1:0] FWD_M  = 2'b10;  // Memory ALU result

    // Wait-counter width; holds timeouts up to 255 cycles.
    localparam int unsigned CNT_W = 8;

endpackage

// File: rtl/forward_sel.sv
// Single-operand forward select: Memory result beats Writeback result, x0 never forwards.
module forward_sel
    import hazard_pkg::*;
(
    input  logic [4:0] rs_e,
    input  logic [4:0] rd_m,
    input  logic [4:0] rd_w,
    input  logic       reg_write_m,
    input  logic       reg_write_w,
    output logic [1:0] fwd
);

    // Priority compare against the younger (Memory) writer first.
    always_comb begin
        fwd = FWD_RF;
        if (rs_e != 5'd0 && reg_write_m && rs_e == rd_m) begin
            fwd = FWD_M;
        end else if (rs_e != 5'd0 && reg_write_w && rs_e == rd_w) begin
            fwd = FWD_W;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: forwarding, load-use stall, branch flush and
// data-memory wait handling with a sticky timeout flag.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] Rs1D,
    input  logic [4:0] Rs2D,
    input  logic [4:0] Rs1E,
    input  logic [4:0] Rs2E,
    input  logic [4:0] RdE,
    input  logic [4:0] RdM,
    input  logic [4:0] RdW,
    input  logic       RegWriteM,
    input  logic       RegWriteW,
    input  logic       ResultSrcE0,
    input  logic       PCSrcE,
    input  logic       MemReqM,
    input  logic       dmem_ack,
    output logic       dmem_req,
    output logic       StallF,
    output logic       StallD,
    output logic       StallE,
    output logic       StallM,
    output logic       FlushD,
    output logic       FlushE,
    output logic       FlushW,
    output logic [1:0] ForwardAE,
    output logic [1:0] ForwardBE,
    output logic       mem_timeout
);

    localparam logic [CNT_W-1:0] TimeoutVal = CNT_W'(TIMEOUT_CYCLES);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;
    logic             mem_stall;
    logic             lw_stall;

    forward_sel u_fwd_a (
        .rs_e        (Rs1E),
        .rd_m        (RdM),
        .rd_w        (RdW),
        .reg_write_m (RegWriteM),
        .reg_write_w (RegWriteW),
        .fwd         (ForwardAE)
    );

    forward_sel u_fwd_b (
        .rs_e        (Rs2E),
        .rd_m        (RdM),
        .rd_w        (RdW),
        .reg_write_m (RegWriteM),
        .reg_write_w (RegWriteW),
        .fwd         (ForwardBE)
    );

    assign lw_stall    = ResultSrcE0 && (RdE != 5'd0) && ((Rs1D == RdE) || (Rs2D == RdE));
    assign mem_timeout = timeout_q;

    // State, wait counter and sticky timeout registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    // Memory handshake next-state, request and stall decode.
    always_comb begin
        state_d   = state_q;
        dmem_req  = 1'b0;
        mem_stall = 1'b0;
        unique case (state_q)
            StIdle: begin
                dmem_req  = MemReqM;
                mem_stall = MemReqM && !dmem_ack;
                if (MemReqM && !dmem_ack) state_d = StMemWait;
            end
            StMemWait: begin
                dmem_req  = 1'b1;
                mem_stall = !dmem_ack;
                if (dmem_ack) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        // Reset abandons any outstanding access immediately.
        if (reset) dmem_req = 1'b0;
    end

    // Wait counter: cleared on entry, saturating count while waiting.
    always_comb begin
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
        if (state_q == StIdle && MemReqM && !dmem_ack) begin
            cnt_d = '0;
        end else if (state_q == StMemWait) begin
            if (cnt_q != TimeoutVal) cnt_d = cnt_q + 1'b1;
            if (!dmem_ack && cnt_d == TimeoutVal) timeout_d = 1'b1;
        end
    end

    // Stage stall/flush outputs; a memory stall masks load-use and branch effects.
    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        StallE = 1'b0;
        StallM = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        FlushW = 1'b0;
        if (reset) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
            FlushW = 1'b1;
        end else if (mem_stall) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            FlushW = 1'b1;
        end else begin
            StallF = lw_stall;
            StallD = lw_stall;
            FlushD = PCSrcE;
            FlushE = lw_stall || PCSrcE;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl (timeout shortened to 4 cycles).
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic       RegWriteM, RegWriteW, ResultSrcE0, PCSrcE, MemReqM, dmem_ack;
    logic       dmem_req, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
    logic [1:0] ForwardAE, ForwardBE;
    logic       mem_timeout;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.TIMEOUT_CYCLES(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .Rs1D        (Rs1D),
        .Rs2D        (Rs2D),
        .Rs1E        (Rs1E),
        .Rs2E        (Rs2E),
        .RdE         (RdE),
        .RdM         (RdM),
        .RdW         (RdW),
        .RegWriteM   (RegWriteM),
        .RegWriteW   (RegWriteW),
        .ResultSrcE0 (ResultSrcE0),
        .PCSrcE      (PCSrcE),
        .MemReqM     (MemReqM),
        .dmem_ack    (dmem_ack),
        .dmem_req    (dmem_req),
        .StallF      (StallF),
        .StallD      (StallD),
        .StallE      (StallE),
        .StallM      (StallM),
        .FlushD      (FlushD),
        .FlushE      (FlushE),
        .FlushW      (FlushW),
        .ForwardAE   (ForwardAE),
        .ForwardBE   (ForwardBE),
        .mem_timeout (mem_timeout)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Packs {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushW} for compact checks.
    function automatic logic [6:0] ctl();
        return {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW};
    endfunction

    task automatic clear_inputs();
        {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
        {RegWriteM, RegWriteW, ResultSrcE0, PCSrcE, MemReqM, dmem_ack} = '0;
    endtask

    // Advance one clock edge, then let inputs be changed away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        clear_inputs();
        reset = 1'b1;
        tick();
        tick();

        // Outputs forced during reset; forwarding still live.
        MemReqM = 1'b1; Rs1E = 5'd5; RdM = 5'd5; RegWriteM = 1'b1;
        settle();
        check_eq("rst_ctl", 32'(ctl()), 32'b0000_111);
        check_eq("rst_req", 32'(dmem_req), 32'd0);
        check_eq("rst_fwd", 32'(ForwardAE), 32'd2);
        check_eq("rst_tmo", 32'(mem_timeout), 32'd0);

        reset = 1'b0;
        clear_inputs();
        settle();
        check_eq("idle_ctl", 32'(ctl()), 32'd0);

        // Forwarding priority and x0 exclusion.
        Rs1E = 5'd5; RdM = 5'd5; RegWriteM = 1'b1; RdW = 5'd5; RegWriteW = 1'b1;
        settle();
        check_eq("fwdA_mem", 32'(ForwardAE), 32'd2);
        RegWriteM = 1'b0;
        settle();
        check_eq("fwdA_wb", 32'(ForwardAE), 32'd1);
        Rs1E = 5'd0; RdM = 5'd0; RdW = 5'd0; RegWriteM = 1'b1;
        settle();
        check_eq("fwdA_x0", 32'(ForwardAE), 32'd0);
        Rs2E = 5'd3; RdM = 5'd4; RdW = 5'd3;
        settle();
        check_eq("fwdB_wb", 32'(ForwardBE), 32'd1);
        clear_inputs();

        // Load-use, branch, and both together.
        ResultSrcE0 = 1'b1; RdE = 5'd7; Rs2D = 5'd7;
        settle();
        check_eq("lw_stall", 32'(ctl()), 32'b1100_010);
        RdE = 5'd0; Rs2D = 5'd0;
        settle();
        check_eq("lw_x0", 32'(ctl()), 32'd0);
        ResultSrcE0 = 1'b0; PCSrcE = 1'b1;
        settle();
        check_eq("branch", 32'(ctl()), 32'b0000_110);
        ResultSrcE0 = 1'b1; RdE = 5'd9; Rs1D = 5'd9;
        settle();
        check_eq("lw_branch", 32'(ctl()), 32'b1100_110);
        clear_inputs();

        // Memory wait: ack low for 3 cycles, then high.
        MemReqM = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle();
            check_eq($sformatf("mw_req%0d", i), 32'(dmem_req), 32'd1);
            check_eq($sformatf("mw_ctl%0d", i), 32'(ctl()), 32'b1111_001);
            tick();
        end
        dmem_ack = 1'b1;
        settle();
        check_eq("mw_ack_req", 32'(dmem_req), 32'd1);
        check_eq("mw_ack_ctl", 32'(ctl()), 32'd0);
        tick();
        clear_inputs();
        settle();
        check_eq("mw_idle", 32'(dmem_req), 32'd0);

        // Same-cycle ack: no stall, stays idle.
        MemReqM = 1'b1; dmem_ack = 1'b1;
        settle();
        check_eq("fast_req", 32'(dmem_req), 32'd1);
        check_eq("fast_ctl", 32'(ctl()), 32'd0);
        tick();
        clear_inputs();
        settle();
        check_eq("fast_idle", 32'(dmem_req), 32'd0);

        // Branch and load-use masked during the wait, applied on ack cycle.
        MemReqM = 1'b1;
        tick();
        PCSrcE = 1'b1; ResultSrcE0 = 1'b1; RdE = 5'd7; Rs2D = 5'd7;
        settle();
        check_eq("prio_wait", 32'(ctl()), 32'b1111_001);
        dmem_ack = 1'b1;
        settle();
        check_eq("prio_ack", 32'(ctl()), 32'b1100_110);
        tick();
        clear_inputs();

        // Timeout after 4 waiting edges, sticky through a later ack.
        MemReqM = 1'b1;
        tick();  // enter wait, count 0
        for (int i = 1; i <= 3; i++) tick();
        settle();
        check_eq("tmo_before", 32'(mem_timeout), 32'd0);
        tick();
        check_eq("tmo_set", 32'(mem_timeout), 32'd1);
        check_eq("tmo_still_wait", 32'(dmem_req), 32'd1);
        dmem_ack = 1'b1;
        tick();
        clear_inputs();
        settle();
        check_eq("tmo_sticky", 32'(mem_timeout), 32'd1);
        check_eq("tmo_idle", 32'(dmem_req), 32'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        settle();
        check_eq("tmo_clear", 32'(mem_timeout), 32'd0);

        // Reset during wait abandons the access at once.
        MemReqM = 1'b1;
        tick();
        MemReqM = 1'b0;
        settle();
        check_eq("rw_in_wait", 32'(dmem_req), 32'd1);
        reset = 1'b1;
        settle();
        check_eq("rw_req_drop", 32'(dmem_req), 32'd0);
        check_eq("rw_ctl", 32'(ctl()), 32'b0000_111);
        tick();
        check_eq("rw_ctl_held", 32'(ctl()), 32'b0000_111);
        reset = 1'b0;
        settle();
        check_eq("rw_idle", 32'(dmem_req), 32'd0);
        check_eq("rw_ctl_rel", 32'(ctl()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Safety bound so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

endmodule
